// File: rtl/tank_pkg.sv
// Shared tank-game definitions: wall map, direction codes, cell size and
// the renderer object-state packing helper.
package tank_pkg;
   localparam int unsigned CELL_PX    = 32;
   localparam int unsigned CELL_SHIFT = $clog2(CELL_PX);

   typedef enum logic [1:0] {UP = 2'b00, DOWN = 2'b01, LEFT = 2'b10, RIGHT = 2'b11} dir_e;
   typedef enum logic [1:0] {ST_IDLE, ST_FLY, ST_EXPLODE} bullet_fsm_e;

   // Indexed WALL_MAP[x_cell][y_cell]: border ring plus a 2x2 block at cells 7..8.
   localparam logic [15:0][15:0] WALL_MAP = {
      16'hFFFF, 16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h8181,
      16'h8181, 16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'hFFFF};

   function automatic logic wall_at(input logic [11:0] px, input logic [11:0] py);
      return WALL_MAP[px[CELL_SHIFT +: 4]][py[CELL_SHIFT +: 4]];
   endfunction

   function automatic logic [31:0] pack_obj(input logic [1:0] obj_type, input logic active,
                                            input logic [9:0] px, input logic [9:0] py,
                                            input logic [1:0] dir, input logic [2:0] row,
                                            input logic [2:0] col);
      return {1'b0, obj_type, active, px, py, dir, row, col};
   endfunction
endpackage

// File: rtl/bullet_collide.sv
// Combinational wall/edge check for a 4x4 projectile about to move STEP
// pixels in direction i_dir; tests both leading corners of the candidate box.
module bullet_collide
   import tank_pkg::*;
(
   input  logic [9:0] i_pos_x,
   input  logic [9:0] i_pos_y,
   input  dir_e       i_dir,
   input  logic [9:0] i_step,
   output logic       o_blocked
);
   logic [11:0] w_x, w_y, w_step, w_lead;

   always_comb begin
      w_x       = {2'b00, i_pos_x};
      w_y       = {2'b00, i_pos_y};
      w_step    = {2'b00, i_step};
      w_lead    = '0;
      o_blocked = 1'b0;
      case (i_dir)
         UP: begin
            w_lead    = w_y - w_step;
            o_blocked = (w_y < w_step) || wall_at(w_x, w_lead) || wall_at(w_x + 12'd3, w_lead);
         end
         DOWN: begin
            w_lead    = w_y + w_step + 12'd3;
            o_blocked = (w_lead >= 12'd512) || wall_at(w_x, w_lead) || wall_at(w_x + 12'd3, w_lead);
         end
         LEFT: begin
            w_lead    = w_x - w_step;
            o_blocked = (w_x < w_step) || wall_at(w_lead, w_y) || wall_at(w_lead, w_y + 12'd3);
         end
         RIGHT: begin
            w_lead    = w_x + w_step + 12'd3;
            o_blocked = (w_lead >= 12'd512) || wall_at(w_lead, w_y) || wall_at(w_lead, w_y + 12'd3);
         end
      endcase
   end
endmodule

// File: rtl/bullet_engine.sv
// Single-bullet projectile engine: launch, tick-paced flight, wall/edge stop and
// tank hit pulse. Define BULLET_EXPLODE_EN to add a timed EXPLODE state.
module bullet_engine
   import tank_pkg::*;
#(
   parameter int         STEP           = 4,
   parameter int         MOVE_DIV       = 2,
   parameter logic [1:0] OBJ_TYPE       = 2'd3,
   parameter int         EXPLODE_CYCLES = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        game_over,
   input  logic        bullet_fire,
   input  logic [1:0]  bullet_direction,
   input  logic [9:0]  tank_x,
   input  logic [9:0]  tank_y,
   input  logic [9:0]  target_x,
   input  logic [9:0]  target_y,
   input  logic        target_active,
   output logic        killed,
   output logic        busy,
   output logic [31:0] bullet_state
);
   localparam int          TW        = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(MOVE_DIV - 1);
   localparam logic [9:0]  STEP_V    = 10'(STEP);
   localparam logic [9:0]  SPAWN_OFS = 10'd14;

`ifdef BULLET_EXPLODE_EN
   localparam bullet_fsm_e AFTER_FLY      = ST_EXPLODE;
   localparam logic        BUSY_AFTER_FLY = 1'b1;
   localparam int          EW       = (EXPLODE_CYCLES > 1) ? $clog2(EXPLODE_CYCLES) : 1;
   localparam logic [EW-1:0] EXP_LAST = EW'(EXPLODE_CYCLES - 1);
   logic [EW-1:0] r_exp_cnt;
`else
   localparam bullet_fsm_e AFTER_FLY      = ST_IDLE;
   localparam logic        BUSY_AFTER_FLY = 1'b0;
`endif

   bullet_fsm_e   r_state;
   dir_e          r_dir;
   logic [9:0]    r_pos_x, r_pos_y;
   logic [TW-1:0] r_tick;
   logic          r_killed, r_busy;

   logic          w_blocked, w_hit, w_tick_due;
   logic [9:0]    w_next_x, w_next_y;
   logic [11:0]   w_bx, w_by, w_gx, w_gy;

   bullet_collide u_collide (
      .i_pos_x  (r_pos_x),
      .i_pos_y  (r_pos_y),
      .i_dir    (r_dir),
      .i_step   (STEP_V),
      .o_blocked(w_blocked)
   );

   assign w_bx       = {2'b00, r_pos_x};
   assign w_by       = {2'b00, r_pos_y};
   assign w_gx       = {2'b00, target_x};
   assign w_gy       = {2'b00, target_y};
   assign w_hit      = target_active && (w_bx <= w_gx + 12'd31) && (w_bx + 12'd3 >= w_gx)
                                     && (w_by <= w_gy + 12'd31) && (w_by + 12'd3 >= w_gy);
   assign w_tick_due = (r_tick == TICK_LAST);

   always_comb begin
      w_next_x = r_pos_x;
      w_next_y = r_pos_y;
      case (r_dir)
         UP:    w_next_y = r_pos_y - STEP_V;
         DOWN:  w_next_y = r_pos_y + STEP_V;
         LEFT:  w_next_x = r_pos_x - STEP_V;
         RIGHT: w_next_x = r_pos_x + STEP_V;
      endcase
   end

   // A hit holds FLY for the cycle killed is high; the exit happens as killed drops.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_dir    <= UP;
         r_pos_x  <= '0;
         r_pos_y  <= '0;
         r_tick   <= '0;
         r_killed <= 1'b0;
         r_busy   <= 1'b0;
      end else if (game_over) begin
         r_killed <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: if (bullet_fire) begin
               r_state <= ST_FLY;
               r_busy  <= 1'b1;
               r_dir   <= dir_e'(bullet_direction);
               r_pos_x <= tank_x + SPAWN_OFS;
               r_pos_y <= tank_y + SPAWN_OFS;
               r_tick  <= '0;
            end
            ST_FLY: begin
               if (r_killed) begin
                  r_killed <= 1'b0;
                  r_state  <= AFTER_FLY;
                  r_busy   <= BUSY_AFTER_FLY;
               end else if (w_hit) begin
                  r_killed <= 1'b1;
               end else begin
                  r_tick <= w_tick_due ? '0 : r_tick + TW'(1);
                  if (w_tick_due) begin
                     if (w_blocked) begin
                        r_state <= AFTER_FLY;
                        r_busy  <= BUSY_AFTER_FLY;
                     end else begin
                        r_pos_x <= w_next_x;
                        r_pos_y <= w_next_y;
                     end
                  end
               end
            end
`ifdef BULLET_EXPLODE_EN
            ST_EXPLODE: if (r_exp_cnt == EXP_LAST) begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
`endif
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef BULLET_EXPLODE_EN
   always_ff @(posedge clk) begin
      if (reset || r_state != ST_EXPLODE) r_exp_cnt <= '0;
      else if (!game_over)                r_exp_cnt <= r_exp_cnt + EW'(1);
   end
`endif

   always_comb begin
      case (r_state)
         ST_FLY:     bullet_state = pack_obj(OBJ_TYPE, 1'b1, r_pos_x, r_pos_y, r_dir, 3'b001, 3'd0);
         ST_EXPLODE: bullet_state = pack_obj(OBJ_TYPE, 1'b0, r_pos_x, r_pos_y, r_dir, 3'b001, 3'd4);
         default:    bullet_state = pack_obj(OBJ_TYPE, 1'b0, '0, '0, 2'b00, '0, '0);
      endcase
   end

   assign killed = r_killed;
   assign busy   = r_busy;
endmodule

// File: tb/tb_bullet_engine.sv
// Bench for bullet_engine: directed scenarios plus random launches, each checked
// cycle by cycle against a trajectory/timeline model derived from the game rules.
module tb_bullet_engine;
   localparam int         STEP = 4;
   localparam int         MD   = 2;
   localparam logic [1:0] OBJ  = 2'd3;
   localparam int         EC   = 8;
`ifdef BULLET_EXPLODE_EN
   localparam int EXP_T = EC;
`else
   localparam int EXP_T = 0;
`endif

   logic        clk = 1'b0;
   logic        reset, game_over, bullet_fire, target_active;
   logic [1:0]  bullet_direction;
   logic [9:0]  tank_x, tank_y, target_x, target_y;
   logic        killed, busy;
   logic [31:0] bullet_state;

   int checks   = 0;
   int failures = 0;

   bullet_engine #(.STEP(STEP), .MOVE_DIV(MD), .OBJ_TYPE(OBJ), .EXPLODE_CYCLES(EC)) dut (
      .clk(clk), .reset(reset), .game_over(game_over), .bullet_fire(bullet_fire),
      .bullet_direction(bullet_direction), .tank_x(tank_x), .tank_y(tank_y),
      .target_x(target_x), .target_y(target_y), .target_active(target_active),
      .killed(killed), .busy(busy), .bullet_state(bullet_state));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         failures++;
         $error("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   // Map: border ring of cells plus a 2x2 block at cells 7..8.
   function automatic bit tb_wall(input int x, input int y);
      int cx = x / 32;
      int cy = y / 32;
      return (cx == 0) || (cx == 15) || (cy == 0) || (cy == 15) ||
             ((cx == 7 || cx == 8) && (cy == 7 || cy == 8));
   endfunction

   function automatic bit tb_blocked(input int x, input int y, input int d);
      case (d)
         0:       return (y - STEP < 0) || tb_wall(x, y - STEP) || tb_wall(x + 3, y - STEP);
         1:       return (y + STEP + 3 >= 512) || tb_wall(x, y + STEP + 3) || tb_wall(x + 3, y + STEP + 3);
         2:       return (x - STEP < 0) || tb_wall(x - STEP, y) || tb_wall(x - STEP, y + 3);
         default: return (x + STEP + 3 >= 512) || tb_wall(x + STEP + 3, y) || tb_wall(x + STEP + 3, y + 3);
      endcase
   endfunction

   function automatic bit tb_hit(input int x, input int y, input int gx, input int gy, input int ga);
      return (ga != 0) && (x <= gx + 31) && (x + 3 >= gx) && (y <= gy + 31) && (y + 3 >= gy);
   endfunction

   function automatic logic [31:0] word(input bit act, input int x, input int y, input int d, input int col);
      logic [9:0] wx = 10'(x);
      logic [9:0] wy = 10'(y);
      logic [1:0] wd = 2'(d);
      logic [2:0] wc = 3'(col);
      return {1'b0, OBJ, act, wx, wy, wd, 3'b001, wc};
   endfunction

   // Launch one bullet and check every cycle until well after it returns to idle.
   task automatic run_flight(input int tx, input int ty, input int d, input int gx, input int gy,
                             input int ga, input int go_at, input int go_len, input int refire_at,
                             output int last_x, output int last_y);
      int px[$];
      int py[$];
      bit hit_end = 0;
      int k_end, te, idle_t, t, k, lim, kills;
      bit forced = 0;
      logic [31:0] ew;
      logic eb, ek;
      px.push_back(tx + 14);
      py.push_back(ty + 14);
      for (int n = 0; n < 300; n++) begin
         k = px.size() - 1;
         if (tb_hit(px[k], py[k], gx, gy, ga)) begin hit_end = 1; break; end
         if (tb_blocked(px[k], py[k], d)) break;
         px.push_back(px[k] + ((d == 3) ? STEP : (d == 2) ? -STEP : 0));
         py.push_back(py[k] + ((d == 1) ? STEP : (d == 0) ? -STEP : 0));
      end
      k_end  = px.size() - 1;
      te     = hit_end ? k_end * MD + 2 : (k_end + 1) * MD;
      idle_t = te + EXP_T;
      lim    = idle_t + go_len + 3;
      last_x = -1;
      last_y = -1;
      kills  = 0;

      tank_x = 10'(tx); tank_y = 10'(ty); bullet_direction = 2'(d);
      target_x = 10'(gx); target_y = 10'(gy); target_active = (ga != 0);
      bullet_fire = 1'b1;
      @(posedge clk); #1 bullet_fire = 1'b0;
      t = 0;
      for (int c = 0; c <= lim; c++) begin
         @(negedge clk);
         if (t < te) begin
            k  = (t / MD > k_end) ? k_end : t / MD;
            ew = word(1'b1, px[k], py[k], d, 0);
            eb = 1'b1;
            ek = hit_end && (t == k_end * MD + 1) && !forced;
         end else if (t < idle_t) begin
            ew = word(1'b0, px[k_end], py[k_end], d, 4);
            eb = 1'b1;
            ek = 1'b0;
         end else begin
            ew = {1'b0, OBJ, 29'd0};
            eb = 1'b0;
            ek = 1'b0;
         end
         check("state_word", bullet_state, ew);
         check("busy", 32'(busy), 32'(eb));
         check("killed", 32'(killed), 32'(ek));
         if (bullet_state[28]) begin
            last_x = int'(bullet_state[27:18]);
            last_y = int'(bullet_state[17:8]);
         end
         if (killed) kills++;
         game_over   = (c >= go_at) && (c < go_at + go_len);
         bullet_fire = (c == refire_at);
         if (c == refire_at) begin
            tank_x = 10'd200; tank_y = 10'd300; bullet_direction = 2'(~d);
         end
         @(posedge clk); #1;
         forced = game_over;
         if (!game_over) t++;
         bullet_fire = 1'b0;
      end
      game_over = 1'b0;
      check("kill_count", 32'(kills), 32'(hit_end));
   endtask

   initial begin
      int lx, ly, tx, ty, d, gx, gy, ga;
      reset = 1'b1; game_over = 1'b0; bullet_fire = 1'b0; bullet_direction = 2'b00;
      tank_x = '0; tank_y = '0; target_x = 10'd400; target_y = 10'd400; target_active = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_word", bullet_state, {1'b0, OBJ, 29'd0});
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_killed", 32'(killed), 32'd0);

      // Reset mid-flight.
      tank_x = 10'd100; tank_y = 10'd100; bullet_direction = 2'b00; bullet_fire = 1'b1;
      @(posedge clk); #1 bullet_fire = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("midflight_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("rst_mid_word", bullet_state, {1'b0, OBJ, 29'd0});
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_killed", 32'(killed), 32'd0);

      // Hit on target at (96,32): stops at pos_x 94 with one killed pulse.
      run_flight(32, 32, 3, 96, 32, 1, 1000, 0, -1, lx, ly);
      check("hit_pos_x", 32'(lx), 32'd94);
      // Same with target inactive: flies on to the right-edge wall.
      run_flight(32, 32, 3, 96, 32, 0, 1000, 0, -1, lx, ly);
      check("edge_pos_x", 32'(lx), 32'd474);
      // Downward into the bottom wall.
      run_flight(32, 32, 1, 400, 400, 1, 1000, 0, -1, lx, ly);
      check("wall_pos_y", 32'(ly), 32'd474);
      // Refire during flight and a 10-cycle game_over freeze.
      run_flight(32, 32, 3, 96, 32, 0, 5, 10, 3, lx, ly);
      check("freeze_pos_x", 32'(lx), 32'd474);

      for (int i = 0; i < 24; i++) begin
         tx = int'($urandom_range(32, 440));
         ty = int'($urandom_range(32, 440));
         d  = int'($urandom_range(0, 3));
         gx = tx + int'($urandom_range(0, 300)) - 150;
         gy = ty + int'($urandom_range(0, 300)) - 150;
         gx = (gx < 0) ? 0 : (gx > 480) ? 480 : gx;
         gy = (gy < 0) ? 0 : (gy > 480) ? 480 : gy;
         ga = ($urandom_range(0, 3) != 0) ? 1 : 0;
         run_flight(tx, ty, d, gx, gy, ga, 1000, 0, -1, lx, ly);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
